// File: rtl/serial_frame_tx.sv
// serial_frame_tx
//   Frames a DATA_W-bit word onto a single idle-high serial line as
//   start(0), data LSB first, optional even-parity bit, stop(1).
//   Every bit is held for CLKS_PER_BIT clocks.
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   tx_valid  a word is offered (only looked at in IDLE)
//   tx_data   word to send, captured on the accept edge
//   tx_ready  block can accept a word (IDLE only)
//   tx_serial registered serial line, idle high
//   tx_busy   a frame is in progress (~tx_ready)
//   tx_done   one-cycle pulse on the first IDLE cycle after STOP
module serial_frame_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    output logic              tx_serial,
    output logic              tx_busy,
    output logic              tx_done
);

    localparam int                IDX_W    = $clog2(DATA_W + 1);
    localparam logic [7:0]        LAST_CNT = 8'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t             r_state,  w_state_nx;
    logic [7:0]         r_cnt,    w_cnt_nx;
    logic [IDX_W-1:0]   r_idx,    w_idx_nx;
    logic [DATA_W-1:0]  r_shift,  w_shift_nx;
    logic               r_par,    w_par_nx;
    logic               r_serial, w_serial_nx;
    logic               r_done,   w_done_nx;
    logic               w_bit_end;

    // Last clock of the current bit period.
    assign w_bit_end = (r_cnt == LAST_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_shift  <= '0;
            r_par    <= 1'b0;
            r_serial <= 1'b1;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_cnt    <= w_cnt_nx;
            r_idx    <= w_idx_nx;
            r_shift  <= w_shift_nx;
            r_par    <= w_par_nx;
            r_serial <= w_serial_nx;
            r_done   <= w_done_nx;
        end
    end

    // The serial line is registered, so the value for each state is
    // computed here on the transition into it; that gives the start bit
    // on the line in the cycle right after the accept edge.
    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_idx_nx    = r_idx;
        w_shift_nx  = r_shift;
        w_par_nx    = r_par;
        w_serial_nx = r_serial;
        w_done_nx   = 1'b0;
        case (r_state)
            IDLE: begin
                w_serial_nx = 1'b1;
                if (tx_valid) begin
                    w_state_nx  = START;
                    w_cnt_nx    = '0;
                    w_idx_nx    = '0;
                    w_shift_nx  = tx_data;
                    w_par_nx    = ^tx_data;
                    w_serial_nx = 1'b0;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_state_nx  = DATA;
                    w_cnt_nx    = '0;
                    w_serial_nx = r_shift[0];
                end else begin
                    w_cnt_nx = r_cnt + 8'd1;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    w_cnt_nx = '0;
                    if (r_idx == LAST_IDX) begin
                        if (PARITY_EN != 0) begin
                            w_state_nx  = PARITY;
                            w_serial_nx = r_par;
                        end else begin
                            w_state_nx  = STOP;
                            w_serial_nx = 1'b1;
                        end
                    end else begin
                        w_idx_nx    = r_idx + 1'b1;
                        w_shift_nx  = r_shift >> 1;
                        w_serial_nx = w_shift_nx[0];
                    end
                end else begin
                    w_cnt_nx = r_cnt + 8'd1;
                end
            end
            PARITY: begin
                if (w_bit_end) begin
                    w_state_nx  = STOP;
                    w_cnt_nx    = '0;
                    w_serial_nx = 1'b1;
                end else begin
                    w_cnt_nx = r_cnt + 8'd1;
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    w_state_nx  = IDLE;
                    w_cnt_nx    = '0;
                    w_serial_nx = 1'b1;
                    w_done_nx   = 1'b1;
                end else begin
                    w_cnt_nx = r_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nx  = IDLE;
                w_cnt_nx    = '0;
                w_serial_nx = 1'b1;
            end
        endcase
    end

    assign tx_ready  = (r_state == IDLE);
    assign tx_busy   = ~tx_ready;
    assign tx_serial = r_serial;
    assign tx_done   = r_done;

endmodule

// File: tb/tb_serial_frame_tx.sv
module tb_serial_frame_tx;

  typedef struct packed {
    logic ser;
    logic busy;
    logic done;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       v0 = 1'b0, v1 = 1'b0;
  logic [7:0] d0 = 8'h00, d1 = 8'h00;
  int         n_chk_all  = 0;
  int         n_fail_all = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int C = (g == 0) ? 4 : 1;
    localparam int P = (g == 0) ? 1 : 0;

    logic       vin, ser, rdy, bsy, dn;
    logic [7:0] din;
    assign vin = (g == 0) ? v0 : v1;
    assign din = (g == 0) ? d0 : d1;

    serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(C), .PARITY_EN(P)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .tx_valid (vin),
      .tx_data  (din),
      .tx_ready (rdy),
      .tx_serial(ser),
      .tx_busy  (bsy),
      .tx_done  (dn)
    );

    exp_t exp_q[$];
    int   rd     = 0;
    int   m_left = 0;
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic push_bit(input logic b);
      repeat (C) exp_q.push_back('{ser: b, busy: 1'b1, done: 1'b0});
    endtask

    task automatic chk(input string nm, input logic a, input logic e);
      n_chk++;
      n_chk_all++;
      if (a !== e) begin
        n_fail++;
        n_fail_all++;
        $display("FAIL %s dut%0d t=%0t: got %0b want %0b", nm, g, $time, a, e);
      end
    endtask

    initial forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_left = 0;
      end else if (m_left > 0) begin
        m_left--;
      end else if (vin) begin
        push_bit(1'b0);
        for (int i = 0; i < 8; i++) push_bit(din[i]);
        if (P != 0) push_bit(^din);
        push_bit(1'b1);
        exp_q.push_back('{ser: 1'b1, busy: 1'b0, done: 1'b1});
        m_left = C * (8 + 2 + P);
      end
    end

    initial forever begin
      exp_t e;
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_serial", ser, 1'b1);
        chk("rst_ready", rdy, 1'b1);
        chk("rst_busy", bsy, 1'b0);
        chk("rst_done", dn, 1'b0);
        rd = exp_q.size();
      end else if (rd < exp_q.size()) begin
        e = exp_q[rd];
        rd++;
        chk("serial", ser, e.ser);
        chk("busy", bsy, e.busy);
        chk("ready", rdy, ~e.busy);
        chk("done", dn, e.done);
      end else begin
        chk("idle_serial", ser, 1'b1);
        chk("idle_ready", rdy, 1'b1);
        chk("idle_busy", bsy, 1'b0);
        chk("idle_done", dn, 1'b0);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    tick(3);
    rst_n = 1'b1;
    tick(2);

    v0 = 1'b1; d0 = 8'hA5; v1 = 1'b1; d1 = 8'hFF;
    tick(1);
    v0 = 1'b0; v1 = 1'b0; d0 = 8'h00; d1 = 8'h00;
    tick(50);

    v0 = 1'b1; d0 = 8'h3C;
    tick(1);
    d0 = 8'hC3;
    tick(45);
    v0 = 1'b0;
    tick(50);

    v0 = 1'b1; d0 = 8'h5A;
    tick(1);
    v0 = 1'b0;
    tick(9);
    v0 = 1'b1; d0 = 8'hFF;
    tick(36);
    v0 = 1'b0;
    tick(50);

    v0 = 1'b1; d0 = 8'($urandom);
    tick(1);
    v0 = 1'b0;
    tick(17);
    rst_n = 1'b0; v0 = 1'b1; d0 = 8'($urandom);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    v0 = 1'b0;
    tick(50);

    repeat (1500) begin
      v0 = ($urandom % 4 == 0); d0 = 8'($urandom);
      v1 = ($urandom % 3 == 0); d1 = 8'($urandom);
      tick(1);
    end
    v0 = 1'b0; v1 = 1'b0;
    tick(60);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk_all, n_fail_all);
    $finish;
  end

endmodule
